pixel_fetch: RTL and testbench

PIXEL_FETCH -- requirements
Module: pixel_fetch

---
 rtl/pixel_fetch_pkg.sv | 31 +++
 rtl/sync_delay.sv | 35 +++
 rtl/pixel_fetch.sv | 122 ++++++++++++
 tb/tb_pixel_fetch.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pixel_fetch_pkg.sv
// Shared defaults and derived constants for the upscaling frame-buffer fetch path.
// Also holds the packed bundle used to carry de/hs/vs through the alignment delay.
package pixel_fetch_pkg;

   localparam int DEF_H_ACT  = 800;
   localparam int DEF_SCALE  = 4;
   localparam int DEF_IMG_W  = 200;
   localparam int DEF_IMG_H  = 150;
   localparam int DEF_RD_LAT = 2;
   localparam int DEF_ADDR_W = 15;
   localparam int DEF_RGB_W  = 12;

   typedef struct packed {
      logic de;
      logic hs;
      logic vs;
   } sync_t;

   // Counter width that stays legal when the range collapses to a single value.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Start address of the last source row; row_base never advances past it.
   function automatic int row_base_max(input int img_w, input int img_h);
      return (img_h - 1) * img_w;
   endfunction

   localparam int DEF_ROW_BASE_MAX = row_base_max(DEF_IMG_W, DEF_IMG_H);

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register that aligns de/hs/vs with the frame-buffer read pipeline.
// dout_pre taps one stage earlier so the rgb register can use it as its load enable.
module sync_delay #(
   parameter int DEPTH = 3,
   parameter int WIDTH = 3
) (
   input  logic             pclk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [WIDTH-1:0] dout_pre
);

   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge pclk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[DEPTH-1];

   generate
      if (DEPTH > 1) begin : g_tap
         assign dout_pre = stage[DEPTH-2];
      end else begin : g_direct
         assign dout_pre = din;
      end
   endgenerate

endmodule

// File: rtl/pixel_fetch.sv
// Generates frame-buffer read addresses for an integer-upscaled image and realigns
// the returned pixel with the display syncs across the read latency.
module pixel_fetch
   import pixel_fetch_pkg::*;
#(
   parameter int H_ACT  = DEF_H_ACT,
   parameter int SCALE  = DEF_SCALE,
   parameter int IMG_W  = DEF_IMG_W,
   parameter int IMG_H  = DEF_IMG_H,
   parameter int RD_LAT = DEF_RD_LAT,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int RGB_W  = DEF_RGB_W
) (
   input  logic              pclk,
   input  logic              rstn,
   input  logic              hen,
   input  logic              ven,
   input  logic              hs_in,
   input  logic              vs_in,
   output logic [ADDR_W-1:0] raddr,
   input  logic [RGB_W-1:0]  rdata,
   output logic [RGB_W-1:0]  rgb,
   output logic              hs_o,
   output logic              vs_o,
   output logic              frame_start
);

   localparam int SX_W = cnt_width(SCALE);
   localparam int COL_W = cnt_width(IMG_W);
   // Never fetch past the narrower of the source image and the scaled active line.
   localparam int COL_LIMIT = ((H_ACT / SCALE) < IMG_W) ? (H_ACT / SCALE) : IMG_W;
   localparam logic [ADDR_W-1:0] ROW_MAX = ADDR_W'(row_base_max(IMG_W, IMG_H));
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

   logic [SX_W-1:0]   sx;
   logic [SX_W-1:0]   sy;
   logic [COL_W-1:0]  col;
   logic [ADDR_W-1:0] row_base;
   logic              de;
   logic              de_q;
   logic              ven_q;
   logic              line_end;
   sync_t             sync_in;
   sync_t             sync_pre;
   sync_t             sync_out;
   logic              unused_de_out;

   assign de       = hen & ven;
   assign line_end = de_q & ~de & ven;

   always_ff @(posedge pclk or negedge rstn) begin
      if (!rstn) begin
         sx       <= '0;
         sy       <= '0;
         col      <= '0;
         row_base <= '0;
      end else if (!ven) begin
         sx       <= '0;
         sy       <= '0;
         col      <= '0;
         row_base <= '0;
      end else if (de) begin
         if (sx == SX_W'(SCALE - 1)) begin
            sx <= '0;
            if (col != COL_W'(COL_LIMIT - 1)) col <= col + 1'b1;
         end else begin
            sx <= sx + 1'b1;
         end
      end else if (line_end) begin
         sx  <= '0;
         col <= '0;
         if (sy == SX_W'(SCALE - 1)) begin
            sy <= '0;
            if (row_base < ROW_MAX) row_base <= row_base + ROW_STEP;
         end else begin
            sy <= sy + 1'b1;
         end
      end
   end

   // Combinational so the address leaves in the same cycle as the pixel's de.
   assign raddr = row_base + ADDR_W'(col);

   always_ff @(posedge pclk or negedge rstn) begin
      if (!rstn) begin
         de_q        <= 1'b0;
         ven_q       <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         de_q        <= de;
         ven_q       <= ven;
         frame_start <= ven & ~ven_q;
      end
   end

   assign sync_in = '{de: de, hs: hs_in, vs: vs_in};

   sync_delay #(
      .DEPTH (RD_LAT + 1),
      .WIDTH (3)
   ) u_sync_delay (
      .pclk     (pclk),
      .rstn     (rstn),
      .din      (sync_in),
      .dout     (sync_out),
      .dout_pre (sync_pre)
   );

   // rdata lands RD_LAT cycles after its address, exactly when the early tap shows its de.
   always_ff @(posedge pclk or negedge rstn) begin
      if (!rstn) begin
         rgb <= '0;
      end else begin
         rgb <= sync_pre.de ? rdata : '0;
      end
   end

   assign hs_o          = sync_out.hs;
   assign vs_o          = sync_out.vs;
   assign unused_de_out = sync_out.de;

endmodule

// File: tb/tb_pixel_fetch.sv
// Scoreboard bench for pixel_fetch: a pixel/line-count reference model predicts
// addresses and aligned outputs; a negedge monitor pops and compares them.
module tb_pixel_fetch;

   localparam int SCALE = 4;
   localparam int IMG_W = 200;
   localparam int IMG_H = 150;

   logic        pclk = 1'b0;
   logic        rstn = 1'b0;
   logic        hen = 1'b0;
   logic        ven = 1'b0;
   logic        hs_in = 1'b0;
   logic        vs_in = 1'b0;
   logic [14:0] raddr;
   logic [11:0] rdata;
   logic [11:0] rgb;
   logic        hs_o;
   logic        vs_o;
   logic        frame_start;

   logic [11:0] mem_p0 = '0;
   logic [11:0] mem_p1 = '0;

   typedef struct {
      logic [11:0] rgb;
      logic        hs;
      logic        vs;
   } out_t;

   out_t out_q[$];
   logic fs_q[$];
   int   tests = 0;
   int   fails = 0;

   int   pix = 0;
   int   line = 0;
   logic m_de_prev = 1'b0;
   logic m_ven_prev = 1'b0;

   always #5 pclk = ~pclk;

   // Frame buffer with two-cycle read latency whose content is the low address bits.
   always @(posedge pclk) begin
      mem_p0 <= raddr[11:0];
      mem_p1 <= mem_p0;
   end
   assign rdata = mem_p1;

   pixel_fetch #(
      .H_ACT  (800),
      .SCALE  (SCALE),
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .RD_LAT (2),
      .ADDR_W (15),
      .RGB_W  (12)
   ) dut (
      .pclk        (pclk),
      .rstn        (rstn),
      .hen         (hen),
      .ven         (ven),
      .hs_in       (hs_in),
      .vs_in       (vs_in),
      .raddr       (raddr),
      .rdata       (rdata),
      .rgb         (rgb),
      .hs_o        (hs_o),
      .vs_o        (vs_o),
      .frame_start (frame_start)
   );

   function automatic int exp_addr(input int p, input int l);
      int r;
      int c;
      r = l / SCALE;
      if (r > IMG_H - 1) r = IMG_H - 1;
      c = p / SCALE;
      if (c > IMG_W - 1) c = IMG_W - 1;
      return r * IMG_W + c;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
      end
   endtask

   // Outputs only move on posedge, so sampling at negedge is race-free.
   always @(negedge pclk) begin
      out_t e;
      logic f;
      if (rstn) begin
         if (out_q.size() == 0 || fs_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL scoreboard at %0t: got empty queue, expected pending entry", $time);
         end else begin
            e = out_q.pop_front();
            f = fs_q.pop_front();
            checkOutput("rgb", 32'(rgb), 32'(e.rgb));
            checkOutput("hs_o", 32'(hs_o), 32'(e.hs));
            checkOutput("vs_o", 32'(vs_o), 32'(e.vs));
            checkOutput("frame_start", 32'(frame_start), 32'(f));
         end
      end
   end

   task automatic applyStimulus(input logic h, input logic v, input logic hs, input logic vs);
      logic        d;
      logic [31:0] a;
      @(negedge pclk);
      #2;
      rstn  = 1'b1;
      hen   = h;
      ven   = v;
      hs_in = hs;
      vs_in = vs;
      d = h & v;
      a = 32'(exp_addr(pix, line));
      #1;
      if (d) checkOutput("raddr", 32'(raddr), a);
      else if (!v && !m_ven_prev) checkOutput("raddr_idle", 32'(raddr), 32'd0);
      out_q.push_back('{rgb: (d ? a[11:0] : 12'd0), hs: hs, vs: vs});
      fs_q.push_back(v & ~m_ven_prev);
      if (!v) begin
         pix  = 0;
         line = 0;
      end else if (d) begin
         pix++;
      end else if (m_de_prev) begin
         pix = 0;
         line++;
      end
      m_de_prev  = d;
      m_ven_prev = v;
   endtask

   task automatic applyReset(input int cycles);
      for (int i = 0; i <= cycles; i++) begin
         if (i > 0) @(negedge pclk);
         #2;
         rstn  = 1'b0;
         hen   = 1'($urandom);
         ven   = 1'($urandom);
         hs_in = 1'($urandom);
         vs_in = 1'($urandom);
         #1;
         checkOutput("rst_rgb", 32'(rgb), 32'd0);
         checkOutput("rst_hs_o", 32'(hs_o), 32'd0);
         checkOutput("rst_vs_o", 32'(vs_o), 32'd0);
         checkOutput("rst_raddr", 32'(raddr), 32'd0);
         checkOutput("rst_frame_start", 32'(frame_start), 32'd0);
      end
      pix        = 0;
      line       = 0;
      m_de_prev  = 1'b0;
      m_ven_prev = 1'b0;
      out_q.delete();
      fs_q.delete();
      repeat (2) out_q.push_back('{rgb: 12'd0, hs: 1'b0, vs: 1'b0});
   endtask

   task automatic applyLine(input int n_de);
      int blank;
      int hsw;
      blank = 4 + int'($urandom_range(6));
      hsw   = 1 + int'($urandom_range(blank - 3));
      for (int i = 0; i < n_de; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < blank; i++) applyStimulus(1'b0, 1'b1, (i >= 1 && i < 1 + hsw), 1'b0);
   endtask

   // Vertical blanking with stray hen activity, which must neither count nor emit pixels.
   task automatic applyVblank(input int cycles);
      for (int c = 0; c < cycles; c++)
         applyStimulus(1'($urandom), 1'b0, ((c % 20) < 3), (c >= 5 && c < 5 + (cycles / 3)));
   endtask

   initial begin
      applyReset(4);
      applyVblank(40);

      for (int l = 0; l < 4; l++) applyLine(800);
      applyLine(810);
      for (int l = 5; l < 605; l++) applyLine(1 + int'($urandom_range(15)));
      applyVblank(60);

      applyLine(800);
      applyLine(810);
      for (int i = 0; i < 400; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      applyReset(3);
      applyLine(400);
      for (int l = 0; l < 6; l++) applyLine(1 + int'($urandom_range(40)));
      applyVblank(30);
      applyLine(12);
      applyVblank(10);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
